// File: rtl/rc_pkg.sv
// Shared types and character constants for the UART receive block.
// RX_PARITY_EN adds an even-parity state to the bit FSM.
package rc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef RX_PARITY_EN
    PARITY,
`endif
    STOP
  } rx_state_e;

  localparam logic [7:0] CHAR_ZERO = 8'h30;
  localparam logic [7:0] CHAR_NINE = 8'h39;
  localparam logic [7:0] CHAR_CR   = 8'h0D;
  localparam logic [7:0] CHAR_ESC  = 8'h1B;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CHAR_ZERO) && (c <= CHAR_NINE);
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Serial byte receiver: 2-FF synchronizer, bit FSM and shift register.
// RX_PARITY_EN inserts an even-parity bit check between data and stop.
module uart_rx_core
  import rc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rxByte,
  output logic       byteValid,
  output logic       byteErr,
  output logic       busy
);

  localparam int            CW   = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e     state, state_n;
  logic          rx_m, rx_s, rx_d;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    sr;
  logic          par_bad;
  logic          fall, tick_half, tick_full;

  // sync stages clear to 0 so a line already low out of reset is not an edge
  assign fall      = rx_d & ~rx_s;
  assign tick_half = (clk_cnt == HALF);
  assign tick_full = (clk_cnt == FULL);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (fall) state_n = START;
      START:  if (tick_half) state_n = rx_s ? IDLE : DATA;
      DATA:   if (tick_full && bit_cnt == 3'd7)
`ifdef RX_PARITY_EN
                state_n = PARITY;
      PARITY: if (tick_full) state_n = STOP;
`else
                state_n = STOP;
`endif
      STOP:   if (tick_full) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m      <= 1'b0;
      rx_s      <= 1'b0;
      rx_d      <= 1'b0;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      sr        <= '0;
      par_bad   <= 1'b0;
      rxByte    <= '0;
      byteValid <= 1'b0;
      byteErr   <= 1'b0;
    end else begin
      rx_m      <= rxd;
      rx_s      <= rx_m;
      rx_d      <= rx_s;
      byteValid <= 1'b0;
      byteErr   <= 1'b0;
      // restart the bit timer on every state change and every sample point
      clk_cnt   <= (state_n != state || tick_full) ? '0 : clk_cnt + CW'(1);
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          par_bad <= 1'b0;
        end
        DATA: if (tick_full) begin
          sr      <= {rx_s, sr[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
`ifdef RX_PARITY_EN
        PARITY: if (tick_full) par_bad <= rx_s ^ (^sr);
`endif
        STOP: if (tick_full) begin
          if (rx_s && !par_bad) begin
            rxByte    <= sr;
            byteValid <= 1'b1;
          end else begin
            byteErr   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_receive.sv
// Decimal-entry receiver: decodes UART characters into a 4-digit buffer.
// Build with RX_PARITY_EN for 8E1 framing; default is 8N1.
module uart_receive
  import rc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int MAX_DIGITS   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [3:0] num1,
  output logic [3:0] num2,
  output logic [3:0] num3,
  output logic [3:0] num4,
  output logic       numValid,
  output logic       frameErr,
  output logic       overflow,
  output logic       busy
);

  logic [7:0] rx_byte;
  logic       byte_valid, byte_err;
  logic [2:0] count;
  logic       pend_clr;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .rxByte    (rx_byte),
    .byteValid (byte_valid),
    .byteErr   (byte_err),
    .busy      (busy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      {num1, num2, num3, num4} <= '0;
      count    <= '0;
      pend_clr <= 1'b0;
      numValid <= 1'b0;
      frameErr <= 1'b0;
      overflow <= 1'b0;
    end else begin
      numValid <= 1'b0;
      frameErr <= byte_err;
      if (byte_valid) begin
        if (is_digit(rx_byte)) begin
          // a committed number stays visible until the next digit replaces it
          if (pend_clr) begin
            {num4, num3, num2} <= '0;
            num1     <= rx_byte[3:0];
            count    <= 3'd1;
            pend_clr <= 1'b0;
          end else if (count == 3'(MAX_DIGITS)) begin
            overflow <= 1'b1;
          end else begin
            {num4, num3, num2, num1} <= {num3, num2, num1, rx_byte[3:0]};
            count <= count + 3'd1;
          end
        end else if (rx_byte == CHAR_CR) begin
          numValid <= 1'b1;
          pend_clr <= 1'b1;
          overflow <= 1'b0;
        end else if (rx_byte == CHAR_ESC) begin
          {num1, num2, num3, num4} <= '0;
          count    <= '0;
          pend_clr <= 1'b0;
          overflow <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_receive.sv
// Directed bench for uart_receive at CLKS_PER_BIT=16.
module tb_uart_receive;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset, rxd;
  logic [3:0] num1, num2, num3, num4;
  logic       numValid, frameErr, overflow, busy;

  int vecs = 0, errs = 0;
  int nv_hi = 0, nv_rise = 0, fe_hi = 0, fe_rise = 0, both_hi = 0;
  logic nv_l = 1'b0, fe_l = 1'b0;
  int n0, h0, f0, g0;

  uart_receive #(.CLKS_PER_BIT(CPB), .MAX_DIGITS(4)) dut (
    .clk(clk), .reset(reset), .rxd(rxd),
    .num1(num1), .num2(num2), .num3(num3), .num4(num4),
    .numValid(numValid), .frameErr(frameErr), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (numValid)             nv_hi   <= nv_hi + 1;
    if (numValid && !nv_l)    nv_rise <= nv_rise + 1;
    if (frameErr)             fe_hi   <= fe_hi + 1;
    if (frameErr && !fe_l)    fe_rise <= fe_rise + 1;
    if (numValid && frameErr) both_hi <= both_hi + 1;
    nv_l <= numValid;
    fe_l <= frameErr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bitw(input logic v);
    rxd = v;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] c, input logic stop_bit);
    bitw(1'b0);
    for (int i = 0; i < 8; i++) bitw(c[i]);
`ifdef RX_PARITY_EN
    bitw(^c);
`endif
    bitw(stop_bit);
    rxd = 1'b1;
    repeat (3 * CPB) @(posedge clk);
  endtask

  task automatic snap();
    @(negedge clk);
    n0 = nv_rise; h0 = nv_hi; f0 = fe_rise; g0 = fe_hi;
  endtask

  function automatic logic [15:0] bufv();
    return {num4, num3, num2, num1};
  endfunction

  initial begin
    reset = 1'b1;
    rxd   = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_buf",  bufv(), 16'h0000);
    chk("rst_flags", {numValid, frameErr, overflow, busy}, 4'b0000);
    reset = 1'b0;
    repeat (2 * CPB) @(posedge clk);

    // '8' then CR
    snap();
    send(8'h38, 1'b1);
    send(8'h0D, 1'b1);
    @(negedge clk);
    chk("cr_buf",    bufv(), 16'h0008);
    chk("cr_nv_cnt", nv_rise - n0, 1);
    chk("cr_nv_wid", nv_hi - h0, 1);
    chk("cr_fe",     fe_rise - f0, 0);

    // fill, overflow, escape
    send(8'h31, 1'b1); send(8'h32, 1'b1); send(8'h33, 1'b1); send(8'h34, 1'b1);
    @(negedge clk);
    chk("fill_buf", bufv(), 16'h1234);
    chk("fill_ovf", overflow, 1'b0);
    send(8'h35, 1'b1);
    @(negedge clk);
    chk("ovf_buf", bufv(), 16'h1234);
    chk("ovf_set", overflow, 1'b1);
    snap();
    send(8'h1B, 1'b1);
    @(negedge clk);
    chk("esc_buf", bufv(), 16'h0000);
    chk("esc_ovf", overflow, 1'b0);
    chk("esc_nv",  nv_rise - n0, 0);

    // commit "12" then a fresh digit
    snap();
    send(8'h31, 1'b1); send(8'h32, 1'b1); send(8'h0D, 1'b1);
    @(negedge clk);
    chk("c12_buf", bufv(), 16'h0012);
    chk("c12_nv",  nv_rise - n0, 1);
    send(8'h37, 1'b1);
    @(negedge clk);
    chk("new_buf", bufv(), 16'h0007);

    // ignored character leaves everything alone
    send(8'h41, 1'b1);
    @(negedge clk);
    chk("ign_buf", bufv(), 16'h0007);

    // bad stop bit
    snap();
    send(8'h35, 1'b0);
    @(negedge clk);
    chk("fe_cnt",  fe_rise - f0, 1);
    chk("fe_wid",  fe_hi - g0, 1);
    chk("fe_buf",  bufv(), 16'h0007);
    chk("fe_busy", busy, 1'b0);
    chk("fe_nv",   nv_rise - n0, 0);

    // 4-cycle glitch
    snap();
    rxd = 1'b0;
    repeat (4) @(posedge clk);
    rxd = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    @(negedge clk);
    chk("gl_fe",   fe_rise - f0, 0);
    chk("gl_busy", busy, 1'b0);
    chk("gl_buf",  bufv(), 16'h0007);

    // reset in bit 4 of '9'
    snap();
    fork
      send(8'h39, 1'b1);
      begin
        repeat (5 * CPB + 8) @(posedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mr_buf",   bufv(), 16'h0000);
        chk("mr_flags", {numValid, frameErr, overflow, busy}, 4'b0000);
      end
    join
    repeat (12 * CPB) @(posedge clk);
    @(negedge clk);
    chk("mr_after", bufv(), 16'h0000);
    chk("mr_nv",    nv_rise - n0, 0);
    chk("mr_fe",    fe_rise - f0, 0);
    send(8'h36, 1'b1);
    @(negedge clk);
    chk("mr_six", bufv(), 16'h0006);

    chk("nv_fe_excl", both_hi, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
